// File: rtl/adc_serial_capture.sv
// adc_serial_capture
//   Serial front end for an ADCS7476-class ADC. The block runs 16-clock frames:
//   4 leading zeros, then 12 data bits MSB first. It drives CS and SCLK, shifts
//   in SO, and delivers 12-bit samples with a one-cycle valid strobe.
//
// Parameters
//   CLK_DIV      : SCLK half-period in clk cycles (>=1)
//   QUIET_CYCLES : minimum CS-high cycles between frames (>=1)
//
// Ports
//   clk          : system clock
//   reset        : asynchronous active-high reset
//   cont         : 1 = back-to-back conversions
//   start        : single-shot request, honoured only when idle
//   adc_cs       : ADC chip select, active low
//   adc_sclk     : ADC serial clock, idles high
//   adc_so       : ADC serial data
//   sample       : last captured conversion
//   sample_valid : one-cycle pulse when sample updates
//   frame_err    : leading bits of the last frame were not all zero
//   busy         : frame or quiet period in progress
module adc_serial_capture #(
  parameter int CLK_DIV      = 2,
  parameter int QUIET_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cont,
  input  logic        start,
  output logic        adc_cs,
  output logic        adc_sclk,
  input  logic        adc_so,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int MAXC = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYCLES - 1);

  // HOLD is the final SCLK-high half period after the last capture.
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, QUIET} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   shreg;
  logic          go;

  assign go = cont | start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      adc_cs       <= 1'b1;
      adc_sclk     <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state  <= SETUP;
            adc_cs <= 1'b0;
            busy   <= 1'b1;
            cnt    <= '0;
          end
        end
        SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            adc_sclk <= 1'b0;
            state    <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!adc_sclk) begin
              // End of low phase: capture SO and raise SCLK on the same edge.
              shreg    <= {shreg[14:0], adc_so};
              adc_sclk <= 1'b1;
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) state <= HOLD;
            end else begin
              adc_sclk <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt          <= '0;
            adc_cs       <= 1'b1;
            sample       <= shreg[11:0];
            frame_err    <= |shreg[15:12];
            sample_valid <= 1'b1;
            state        <= QUIET;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        QUIET: begin
          if (cnt == QUIET_LAST) begin
            cnt <= '0;
            // A request on the last quiet edge starts the next frame directly.
            if (go) begin
              state  <= SETUP;
              adc_cs <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: one instance at default parameters and one
// at CLK_DIV=1/QUIET_CYCLES=1, each fed by a behavioural ADC model.
module tb_adc_serial_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cont0 = 1'b0, start0 = 1'b0, so0 = 1'b0;
  logic        cs0, sc0, v0, e0, b0;
  logic [11:0] s0;
  logic        cont1 = 1'b0, start1 = 1'b0, so1 = 1'b0;
  logic        cs1, sc1, v1, e1, b1;
  logic [11:0] s1;

  adc_serial_capture dut0 (
    .clk(clk), .reset(rst), .cont(cont0), .start(start0),
    .adc_cs(cs0), .adc_sclk(sc0), .adc_so(so0),
    .sample(s0), .sample_valid(v0), .frame_err(e0), .busy(b0));

  adc_serial_capture #(.CLK_DIV(1), .QUIET_CYCLES(1)) dut1 (
    .clk(clk), .reset(rst), .cont(cont1), .start(start1),
    .adc_cs(cs1), .adc_sclk(sc1), .adc_so(so1),
    .sample(s1), .sample_valid(v1), .frame_err(e1), .busy(b1));

  int sel = 0;
  logic        m_cs, m_sclk, m_valid, m_err, m_busy;
  logic [11:0] m_sample;
  assign m_cs     = sel ? cs1 : cs0;
  assign m_sclk   = sel ? sc1 : sc0;
  assign m_valid  = sel ? v1  : v0;
  assign m_err    = sel ? e1  : e0;
  assign m_busy   = sel ? b1  : b0;
  assign m_sample = sel ? s1  : s0;

  // ADC model: a frame word is taken from the queue on the CS fall; bit k is
  // presented after k SCLK rising edges; SO is junk whenever CS is high.
  logic [15:0] q0[$], q1[$];
  logic [15:0] w0 = '0, w1 = '0;
  int   i0 = 0, i1 = 0;
  logic pcs0 = 1'b1, psc0 = 1'b1, pcs1 = 1'b1, psc1 = 1'b1;

  always @(negedge clk) begin
    if (!cs0 && pcs0) begin
      w0 = (q0.size() > 0) ? q0.pop_front() : 16'($urandom);
      i0 = 0;
    end else if (!cs0 && sc0 && !psc0) i0++;
    pcs0 = cs0; psc0 = sc0;
    so0 = (!cs0 && i0 < 16) ? w0[15-i0] : 1'($urandom);
  end

  always @(negedge clk) begin
    if (!cs1 && pcs1) begin
      w1 = (q1.size() > 0) ? q1.pop_front() : 16'($urandom);
      i1 = 0;
    end else if (!cs1 && sc1 && !psc1) i1++;
    pcs1 = cs1; psc1 = sc1;
    so1 = (!cs1 && i1 < 16) ? w1[15-i1] : 1'($urandom);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_cont(input int s, input logic v);
    if (s == 0) cont0 = v; else cont1 = v;
  endtask

  // One single-shot frame; checks CS width, SCLK edges, capture timing,
  // the valid pulse, the captured value and the quiet period.
  task automatic do_frame(input int s, input logic [15:0] w, input logic [11:0] es,
                          input logic ee, input int D, input int Q, input bit poke);
    int c, rises, first_r, last_r, nv, lows;
    logic psc;
    bit early;
    sel = s;
    if (s == 0) q0.push_back(w); else q1.push_back(w);
    @(negedge clk); set_start(s, 1'b1);
    @(negedge clk); set_start(s, 1'b0);
    chk("cs_fall", m_cs, 1'b0);
    chk("busy_set", m_busy, 1'b1);
    c = 0; rises = 0; first_r = 0; last_r = 0; psc = m_sclk; early = 0;
    while (m_cs == 1'b0 && c < 40*D + 10) begin
      @(negedge clk); c++;
      if (poke && c == 5) set_start(s, 1'b1);
      if (poke && c == 6) set_start(s, 1'b0);
      if (!m_cs && m_sclk && !psc) begin
        rises++;
        if (rises == 1) first_r = c;
        last_r = c;
      end
      if (!m_cs && m_valid) early = 1;
      psc = m_sclk;
    end
    chk("cs_low_width", c, 33*D);
    chk("sclk_rises", rises, 16);
    chk("first_capture", first_r, 2*D);
    chk("last_capture", last_r, 32*D);
    chk("early_valid", early, 0);
    chk("valid_pulse", m_valid, 1'b1);
    chk("sample", m_sample, es);
    chk("frame_err", m_err, ee);
    nv = 0;
    while (m_busy && c < 33*D + Q + 10) begin
      @(negedge clk); c++;
      if (m_valid) nv++;
    end
    chk("busy_clear_time", c, 33*D + Q);
    chk("valid_one_cycle", nv, 0);
    lows = 0;
    repeat (10) begin
      @(negedge clk);
      if (!m_cs) lows++;
    end
    chk("no_refire", lows, 0);
    chk("sample_hold", m_sample, es);
  endtask

  // Continuous mode for three frames, cont dropped mid-way through the third.
  task automatic run_cont(input int s, input int D, input int Q,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] d);
    int c, nf, nv, P;
    int ft[3];
    logic [11:0] vs[3];
    logic pcs;
    P = 33*D + Q; sel = s;
    if (s == 0) begin q0.push_back(a); q0.push_back(b); q0.push_back(d); end
    else begin q1.push_back(a); q1.push_back(b); q1.push_back(d); end
    for (int k = 0; k < 3; k++) begin ft[k] = 0; vs[k] = '0; end
    @(negedge clk); set_cont(s, 1'b1);
    c = 0; nf = 0; nv = 0; pcs = 1'b1;
    while (c < 4*P + 40) begin
      @(negedge clk); c++;
      if (!m_cs && pcs) begin
        if (nf < 3) ft[nf] = c;
        nf++;
      end
      pcs = m_cs;
      if (m_valid) begin
        if (nv < 3) vs[nv] = m_sample;
        nv++;
      end
      if (nf == 3 && c == ft[2] + P/2) set_cont(s, 1'b0);
    end
    set_cont(s, 1'b0);
    chk("cont_falls", nf, 3);
    chk("cont_first_fall", ft[0], 1);
    chk("cont_period1", ft[1] - ft[0], P);
    chk("cont_period2", ft[2] - ft[1], P);
    chk("cont_valids", nv, 3);
    chk("cont_v0", vs[0], a[11:0]);
    chk("cont_v1", vs[1], b[11:0]);
    chk("cont_v2", vs[2], d[11:0]);
    chk("cont_idle", m_busy, 1'b0);
  endtask

  typedef struct {
    logic [15:0] w;
    logic [11:0] s;
    logic        e;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [15:0] rw;
    int   c;
    bit   seen;

    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [15:0] rw;
    int   nv;
    bit   bad;

    vecs[0] = '{16'h0ABC, 12'hABC, 1'b0};
    vecs[1] = '{16'hFFFF, 12'hFFF, 1'b1};
    vecs[2] = '{16'h0001, 12'h001, 1'b0};
    vecs[3] = '{16'h8000, 12'h000, 1'b1};
    vecs[4] = '{16'h0FFF, 12'hFFF, 1'b0};
    vecs[5] = '{16'h1000, 12'h000, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle with no requests.
    sel = 0; nv = 0; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (v0) nv++;
      if (!cs0 || !sc0 || b0) bad = 1;
    end
    chk("idle_cs", cs0, 1'b1);
    chk("idle_sclk", sc0, 1'b1);
    chk("idle_sample", s0, 12'h000);
    chk("idle_busy", b0, 1'b0);
    chk("idle_err", e0, 1'b0);
    chk("idle_valid_seen", nv, 0);
    chk("idle_pins_stable", bad, 0);

    for (int k = 0; k < 6; k++)
      do_frame(0, vecs[k].w, vecs[k].s, vecs[k].e, 2, 4, 0);

    // Random frames against the reference rule: low 12 bits, OR of top 4.
    for (int k = 0; k < 8; k++) begin
      rw = 16'($urandom);
      do_frame(0, rw, rw[11:0], |rw[15:12], 2, 4, 0);
    end

    run_cont(0, 2, 4, 16'h0123, 16'h0456, 16'h0789);

    // Reset during SCLK low phase (F+18 is a falling edge at CLK_DIV=2).
    sel = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    q0.push_back(16'h0DEF);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (18) @(negedge clk);
    chk("pre_reset_cs", cs0, 1'b0);
    chk("pre_reset_sclk", sc0, 1'b0);
    rst = 1'b1;
    #1;
    chk("reset_cs_async", cs0, 1'b1);
    chk("reset_sclk_async", sc0, 1'b1);
    chk("reset_valid", v0, 1'b0);
    chk("reset_busy", b0, 1'b0);
    @(negedge clk); rst = 1'b0;
    nv = 0;
    repeat (80) begin
      @(negedge clk);
      if (v0) nv++;
    end
    chk("partial_no_valid", nv, 0);
    chk("partial_sample", s0, 12'h000);
    chk("partial_cs", cs0, 1'b1);
    do_frame(0, 16'h0321, 12'h321, 1'b0, 2, 4, 0);

    // Fast instance: start pulsed while busy must be ignored.
    do_frame(1, 16'h5A5A, 12'hA5A, 1'b1, 1, 1, 1);
    do_frame(1, 16'h0C3C, 12'hC3C, 1'b0, 1, 1, 1);
    run_cont(1, 1, 1, 16'h0111, 16'h0F22, 16'h0333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
